// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM: shared prescaler and period counter, per-channel duty and polarity.
// Period, prescale, duty and mode are shadowed and take effect only at a period boundary.
module pwm_multi_channel #(
  parameter int NUM_CH         = 4,
  parameter int MOD_WIDTH      = 8,
  parameter int PRESCALE_WIDTH = 8,
  localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      center_mode,
  input  logic                      wr_period,
  input  logic [MOD_WIDTH-1:0]      period_in,
  input  logic [PRESCALE_WIDTH-1:0] prescale_in,
  input  logic                      wr_duty,
  input  logic [CH_W-1:0]           duty_ch,
  input  logic [MOD_WIDTH:0]        duty_in,
  input  logic [NUM_CH-1:0]         pol,
  output logic [NUM_CH-1:0]         pwm_out,
  output logic                      period_strobe,
  output logic                      busy
);

  logic [MOD_WIDTH-1:0]      r_per_s, r_per_a, r_cnt;
  logic [PRESCALE_WIDTH-1:0] r_psc_s, r_psc_a, r_psc;
  logic [MOD_WIDTH:0]        r_duty_s [NUM_CH];
  logic [MOD_WIDTH:0]        r_duty_a [NUM_CH];
  logic                      r_center_a, r_dir_down, r_busy, r_strobe;
  logic [NUM_CH-1:0]         r_pwm;

  logic [NUM_CH-1:0]         w_raw;
  logic [MOD_WIDTH-1:0]      w_cnt_next;
  logic                      w_tick, w_boundary, w_dir_next, w_duty_ok;

  assign w_tick    = (r_psc == r_psc_a);
  assign w_duty_ok = (32'(duty_ch) < NUM_CH);

  // Next counter value, direction and boundary flag, assuming this cycle is a tick.
  always_comb begin
    w_cnt_next = r_cnt;
    w_dir_next = r_dir_down;
    w_boundary = 1'b0;
    if (!r_center_a) begin
      if (r_cnt >= r_per_a) begin
        w_cnt_next = '0;
        w_boundary = 1'b1;
      end else begin
        w_cnt_next = r_cnt + 1'b1;
      end
    end else if (r_per_a == '0) begin
      w_cnt_next = '0;
      w_boundary = 1'b1;
    end else if (!r_dir_down && (r_cnt < r_per_a)) begin
      w_cnt_next = r_cnt + 1'b1;
    end else begin
      w_cnt_next = r_cnt - 1'b1;
      w_boundary = (w_cnt_next == '0);
      w_dir_next = !w_boundary;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_raw[i] = ({1'b0, r_cnt} < r_duty_a[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_per_s    <= '0;
      r_per_a    <= '0;
      r_psc_s    <= '0;
      r_psc_a    <= '0;
      r_psc      <= '0;
      r_cnt      <= '0;
      r_center_a <= 1'b0;
      r_dir_down <= 1'b0;
      r_busy     <= 1'b0;
      r_strobe   <= 1'b0;
      r_pwm      <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_duty_s[i] <= '0;
        r_duty_a[i] <= '0;
      end
    end else begin
      if (wr_period) begin
        r_per_s <= period_in;
        r_psc_s <= prescale_in;
      end
      if (wr_duty && w_duty_ok) begin
        r_duty_s[duty_ch] <= duty_in;
      end
      r_strobe <= 1'b0;
      r_pwm    <= ((r_busy && en) ? w_raw : '0) ^ pol;

      // Loads below read the shadow before this cycle's writes land.
      if (!en || !r_busy || (w_tick && w_boundary)) begin
        r_per_a    <= r_per_s;
        r_psc_a    <= r_psc_s;
        r_center_a <= center_mode;
        for (int i = 0; i < NUM_CH; i++) begin
          r_duty_a[i] <= r_duty_s[i];
        end
      end

      if (!en) begin
        r_busy     <= 1'b0;
        r_psc      <= '0;
        r_cnt      <= '0;
        r_dir_down <= 1'b0;
      end else if (!r_busy) begin
        r_busy     <= 1'b1;
        r_psc      <= '0;
        r_cnt      <= '0;
        r_dir_down <= 1'b0;
        r_strobe   <= 1'b1;
      end else if (w_tick) begin
        r_psc      <= '0;
        r_cnt      <= w_cnt_next;
        r_dir_down <= w_dir_next;
        r_strobe   <= w_boundary;
      end else begin
        r_psc <= r_psc + 1'b1;
      end
    end
  end

  assign pwm_out       = r_pwm;
  assign period_strobe = r_strobe;
  assign busy          = r_busy;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Bench for pwm_multi_channel: directed scenarios plus random traffic, all checked against
// a period-position model (clock index within the period -> counter value by arithmetic).
module tb_pwm_multi_channel;
  localparam int NCH = 4;

  logic       clk = 1'b0;
  logic       rst, en, center_mode, wr_period, wr_duty;
  logic [7:0] period_in, prescale_in;
  logic [1:0] duty_ch;
  logic [8:0] duty_in;
  logic [3:0] pol;
  logic [3:0] pwm_out;
  logic       period_strobe, busy;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         m_per_s = 0, m_psc_s = 0, m_per_a = 0, m_psc_a = 0, m_k = 0;
  int         m_duty_s [NCH];
  int         m_duty_a [NCH];
  bit         m_center_a = 1'b0, m_run = 1'b0;
  logic [3:0] exp_pwm = '0;
  logic       exp_strobe = 1'b0, exp_busy = 1'b0;

  pwm_multi_channel #(.NUM_CH(NCH), .MOD_WIDTH(8), .PRESCALE_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .en(en), .center_mode(center_mode),
    .wr_period(wr_period), .period_in(period_in), .prescale_in(prescale_in),
    .wr_duty(wr_duty), .duty_ch(duty_ch), .duty_in(duty_in), .pol(pol),
    .pwm_out(pwm_out), .period_strobe(period_strobe), .busy(busy)
  );

  always #5 clk = ~clk;

  // Period length in clocks and counter value at clock index m_k of the period.
  function automatic int m_len();
    int ticks;
    if (m_center_a) ticks = (m_per_a == 0) ? 1 : 2 * m_per_a;
    else            ticks = m_per_a + 1;
    return ticks * (m_psc_a + 1);
  endfunction

  function automatic int m_cnt();
    int t;
    t = m_k / (m_psc_a + 1);
    return (m_center_a && t > m_per_a) ? 2 * m_per_a - t : t;
  endfunction

  function automatic void m_load();
    m_per_a    = m_per_s;
    m_psc_a    = m_psc_s;
    m_center_a = center_mode;
    for (int i = 0; i < NCH; i++) m_duty_a[i] = m_duty_s[i];
  endfunction

  // Predict registered outputs after the coming clock edge from the current inputs.
  function automatic void model_step();
    logic [3:0] raw;
    int cnt;
    if (rst) begin
      m_per_s = 0; m_psc_s = 0; m_per_a = 0; m_psc_a = 0; m_k = 0;
      m_center_a = 1'b0; m_run = 1'b0;
      for (int i = 0; i < NCH; i++) begin m_duty_s[i] = 0; m_duty_a[i] = 0; end
      exp_pwm = '0; exp_strobe = 1'b0; exp_busy = 1'b0;
    end else begin
      exp_strobe = 1'b0;
      if (!en) begin
        m_run = 1'b0; exp_pwm = pol; exp_busy = 1'b0;
        m_load();
      end else if (!m_run) begin
        m_run = 1'b1; m_k = 0; m_load();
        exp_pwm = pol; exp_strobe = 1'b1; exp_busy = 1'b1;
      end else begin
        cnt = m_cnt();
        for (int i = 0; i < NCH; i++) raw[i] = (cnt < m_duty_a[i]);
        exp_pwm  = raw ^ pol;
        exp_busy = 1'b1;
        if (m_k + 1 >= m_len()) begin
          m_k = 0; m_load(); exp_strobe = 1'b1;
        end else begin
          m_k++;
        end
      end
      if (wr_period) begin m_per_s = int'(period_in); m_psc_s = int'(prescale_in); end
      if (wr_duty && int'(duty_ch) < NCH) m_duty_s[duty_ch] = int'(duty_in);
    end
  endfunction

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
    wr_period = 1'b0;
    wr_duty   = 1'b0;
  endtask

  task automatic write_period(input int p, input int d);
    period_in = 8'(p); prescale_in = 8'(d); wr_period = 1'b1;
    advance();
  endtask

  task automatic write_duty(input int ch, input int v);
    duty_ch = 2'(ch); duty_in = 9'(v); wr_duty = 1'b1;
    advance();
  endtask

  task automatic wait_strobe(input string tag);
    int n;
    n = 0;
    do begin advance(); n++; end while (period_strobe !== 1'b1 && n < 200);
    checks++;
    if (period_strobe !== 1'b1) begin
      errors++;
      $display("FAIL %s strobe_timeout: waited %0d cycles, required a strobe within 200", tag, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; center_mode = 1'b0; wr_period = 1'b0; wr_duty = 1'b0;
    period_in = '0; prescale_in = '0; duty_ch = '0; duty_in = '0; pol = '0;
    advance(); advance();
    checks++;
    if ({pwm_out, period_strobe, busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset: got pwm=%b strobe=%b busy=%b, expected all 0", pwm_out, period_strobe, busy);
    end
  endtask

  task automatic test_edge_basic();
    int hi[NCH];
    int strobes;
    rst = 1'b0; en = 1'b0; center_mode = 1'b0; pol = '0;
    write_period(9, 0);
    write_duty(0, 3); write_duty(1, 0); write_duty(2, 10); write_duty(3, 5);
    en = 1'b1;
    for (int c = 0; c < 25; c++) begin
      advance();
      checks++;
      if ({pwm_out, period_strobe, busy} !== {exp_pwm, exp_strobe, exp_busy}) begin
        errors++;
        $display("FAIL edge_basic c%0d: got pwm=%b strobe=%b busy=%b, expected pwm=%b strobe=%b busy=%b",
                 c, pwm_out, period_strobe, busy, exp_pwm, exp_strobe, exp_busy);
      end
    end
    wait_strobe("edge_basic");
    strobes = 0;
    for (int i = 0; i < NCH; i++) hi[i] = 0;
    for (int c = 0; c < 10; c++) begin
      advance();
      for (int i = 0; i < NCH; i++) hi[i] += int'(pwm_out[i]);
      strobes += int'(period_strobe);
    end
    checks++;
    if (hi[0] != 3 || hi[1] != 0 || hi[2] != 10 || hi[3] != 5) begin
      errors++;
      $display("FAIL edge_duty_counts: got %0d/%0d/%0d/%0d high of 10, expected 3/0/10/5",
               hi[0], hi[1], hi[2], hi[3]);
    end
    checks++;
    if (strobes != 1 || period_strobe !== 1'b1) begin
      errors++;
      $display("FAIL edge_strobe_period: got %0d strobes in 10 clks (last=%b), expected 1 ending on the 10th",
               strobes, period_strobe);
    end
  endtask

  // P=4, D=1: counter 0,1,2,3,4,3,2,1 at 2 clks each; duty 2 is high for 0,1,1 -> 6 clks of 16.
  task automatic test_center();
    int hi0, strobes;
    center_mode = 1'b1;
    write_period(4, 1);
    write_duty(0, 2);
    wait_strobe("center");
    hi0 = 0; strobes = 0;
    for (int c = 0; c < 16; c++) begin
      advance();
      hi0 += int'(pwm_out[0]);
      strobes += int'(period_strobe);
      checks++;
      if ({pwm_out, period_strobe, busy} !== {exp_pwm, exp_strobe, exp_busy}) begin
        errors++;
        $display("FAIL center c%0d: got pwm=%b strobe=%b busy=%b, expected pwm=%b strobe=%b busy=%b",
                 c, pwm_out, period_strobe, busy, exp_pwm, exp_strobe, exp_busy);
      end
    end
    checks++;
    if (hi0 != 6 || strobes != 1 || period_strobe !== 1'b1) begin
      errors++;
      $display("FAIL center_counts: got ch0 high %0d, strobes %0d, expected 6 and 1 per 16 clks", hi0, strobes);
    end
  endtask

  task automatic test_duty_update();
    int hi_a, hi_b, n;
    center_mode = 1'b0;
    write_period(9, 0);
    write_duty(0, 3);
    wait_strobe("duty_update");
    for (int c = 0; c < 3; c++) advance();
    write_duty(0, 7);
    n = 0;
    do begin
      advance(); n++;
      checks++;
      if ({pwm_out, period_strobe, busy} !== {exp_pwm, exp_strobe, exp_busy}) begin
        errors++;
        $display("FAIL duty_mid c%0d: got pwm=%b strobe=%b, expected pwm=%b strobe=%b",
                 n, pwm_out, period_strobe, exp_pwm, exp_strobe);
      end
    end while (n < 30 && !(m_run && m_k + 1 >= m_len()));
    write_duty(0, 2);
    checks++;
    if (period_strobe !== 1'b1) begin
      errors++;
      $display("FAIL duty_boundary_strobe: got strobe=%b, expected 1 on the write cycle", period_strobe);
    end
    hi_a = int'(pwm_out[0]);
    for (int c = 0; c < 9; c++) begin advance(); hi_a += int'(pwm_out[0]); end
    hi_b = 0;
    for (int c = 0; c < 10; c++) begin advance(); hi_b += int'(pwm_out[0]); end
    checks++;
    if (hi_a != 7 || hi_b != 2) begin
      errors++;
      $display("FAIL duty_boundary_write: got ch0 high %0d then %0d, expected 7 then 2", hi_a, hi_b);
    end
  endtask

  task automatic test_polarity();
    for (int i = 0; i < NCH; i++) write_duty(i, 0);
    pol = 4'b0101;
    wait_strobe("polarity");
    for (int c = 0; c < 3; c++) advance();
    checks++;
    if (pwm_out !== 4'b0101 || busy !== 1'b1) begin
      errors++;
      $display("FAIL polarity_zero_duty: got pwm=%b busy=%b, expected pwm=0101 busy=1", pwm_out, busy);
    end
    en = 1'b0;
    advance();
    checks++;
    if (pwm_out !== 4'b0101 || busy !== 1'b0 || period_strobe !== 1'b0) begin
      errors++;
      $display("FAIL disable_mid: got pwm=%b busy=%b strobe=%b, expected pwm=0101 busy=0 strobe=0",
               pwm_out, busy, period_strobe);
    end
  endtask

  task automatic test_period_change();
    int n;
    pol = '0; en = 1'b1;
    write_period(3, 3);
    wait_strobe("period_change");
    wait_strobe("period_change");
    for (int pass = 0; pass < 3; pass++) begin
      n = 0;
      if (pass == 1) begin
        for (int c = 0; c < 5; c++) begin advance(); n++; end
        write_period(7, 3); n++;
      end
      do begin
        advance(); n++;
        checks++;
        if ({pwm_out, period_strobe, busy} !== {exp_pwm, exp_strobe, exp_busy}) begin
          errors++;
          $display("FAIL period_change p%0d c%0d: got pwm=%b strobe=%b, expected pwm=%b strobe=%b",
                   pass, n, pwm_out, period_strobe, exp_pwm, exp_strobe);
        end
      end while (period_strobe !== 1'b1 && n < 60);
      checks++;
      if (n != ((pass == 2) ? 32 : 16)) begin
        errors++;
        $display("FAIL period_length p%0d: got %0d clks, expected %0d", pass, n, (pass == 2) ? 32 : 16);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] seen;
    write_period(5, 0);
    write_duty(1, 4);
    advance();
    duty_ch = 2'd2; duty_in = 9'd9; wr_duty = 1'b1; rst = 1'b1;
    advance();
    checks++;
    if ({pwm_out, period_strobe, busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_mid: got pwm=%b strobe=%b busy=%b, expected all 0", pwm_out, period_strobe, busy);
    end
    rst = 1'b0;
    seen = '0;
    for (int c = 0; c < 20; c++) begin
      advance();
      seen |= pwm_out;
      checks++;
      if ({pwm_out, period_strobe, busy} !== {exp_pwm, exp_strobe, exp_busy}) begin
        errors++;
        $display("FAIL after_reset c%0d: got pwm=%b strobe=%b busy=%b, expected pwm=%b strobe=%b busy=%b",
                 c, pwm_out, period_strobe, busy, exp_pwm, exp_strobe, exp_busy);
      end
    end
    checks++;
    if (seen !== 4'b0) begin
      errors++;
      $display("FAIL after_reset_low: got OR of outputs %b, expected 0000", seen);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 39) == 0) en = ~en;
      if ($urandom_range(0, 49) == 0) center_mode = ~center_mode;
      if ($urandom_range(0, 49) == 0) pol = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) begin
        wr_period = 1'b1; period_in = 8'($urandom_range(0, 12)); prescale_in = 8'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 5) == 0) begin
        wr_duty = 1'b1; duty_ch = 2'($urandom_range(0, 3)); duty_in = 9'($urandom_range(0, 14));
      end
      advance();
      checks++;
      if ({pwm_out, period_strobe, busy} !== {exp_pwm, exp_strobe, exp_busy}) begin
        errors++;
        $display("FAIL random c%0d: got pwm=%b strobe=%b busy=%b, expected pwm=%b strobe=%b busy=%b",
                 c, pwm_out, period_strobe, busy, exp_pwm, exp_strobe, exp_busy);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NCH; i++) begin m_duty_s[i] = 0; m_duty_a[i] = 0; end
    test_reset();
    test_edge_basic();
    test_center();
    test_duty_update();
    test_polarity();
    test_period_change();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
